// File: rtl/pc_stack_unit.sv
// pc_stack_unit
//   Program counter with edge- or level-qualified stepping, absolute jump,
//   signed relative branch and a hardware call/return stack.
//   Exactly one action per cycle: jump > call > ret > branch > incr.
//
// Parameters
//   SIZE      PC width; all PC arithmetic wraps modulo 2^SIZE
//   DEPTH     call-stack entries (>= 1)
//   STEP      increment applied on a qualified incr and to the return address
//   RESET_VEC PC value after reset
//   EDGE_MODE 1: incr acts on its rising edge, 0: on every high cycle
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   incr                  step request
//   jump, branch          absolute load / relative branch strobes
//   call, ret             push-and-jump / pop strobes
//   target                address for jump and call
//   offset                two's-complement offset for branch
//   err_clr               clears the sticky error flags
//   pc                    registered program counter
//   sp                    occupied stack entries
//   full, empty           decoded from registered sp
//   err_ovf, err_unf      sticky: call while full / ret while empty
module pc_stack_unit #(
    parameter int SIZE      = 8,
    parameter int DEPTH     = 4,
    parameter int STEP      = 1,
    parameter int RESET_VEC = 0,
    parameter int EDGE_MODE = 1,
    localparam int SPW      = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            incr,
    input  logic            jump,
    input  logic            branch,
    input  logic            call,
    input  logic            ret,
    input  logic [SIZE-1:0] target,
    input  logic [SIZE-1:0] offset,
    input  logic            err_clr,
    output logic [SIZE-1:0] pc,
    output logic [SPW-1:0]  sp,
    output logic            full,
    output logic            empty,
    output logic            err_ovf,
    output logic            err_unf
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SIZE-1:0] STEP_V  = SIZE'(STEP);
    localparam logic [SIZE-1:0] RESET_V = SIZE'(RESET_VEC);
    localparam logic [SPW-1:0]  DEPTH_V = SPW'(DEPTH);
    localparam logic [SPW-1:0]  ONE_SP  = SPW'(1);

    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_JUMP,
        CMD_CALL,
        CMD_RET,
        CMD_BRANCH,
        CMD_INCR
    } cmd_t;

    logic [SIZE-1:0] stack [DEPTH];

    logic            incr_d;
    logic            incr_q;
    cmd_t            cmd;

    logic [SIZE-1:0] pc_nxt;
    logic [SPW-1:0]  sp_nxt;
    logic [SPW-1:0]  sp_dec;
    logic [IDXW-1:0] push_idx;
    logic [IDXW-1:0] pop_idx;
    logic            push_en;
    logic            ovf_set;
    logic            unf_set;

    assign full  = (sp == DEPTH_V);
    assign empty = (sp == '0);

    assign incr_q = (EDGE_MODE != 0) ? (incr & ~incr_d) : incr;

    // Only meaningful when the index is in range (push while !full,
    // pop while !empty); slicing keeps the index width matched to the array.
    assign sp_dec   = sp - ONE_SP;
    assign push_idx = sp[IDXW-1:0];
    assign pop_idx  = sp_dec[IDXW-1:0];

    // Priority decode: lower-priority requests are simply dropped.
    always_comb begin
        cmd = CMD_NONE;
        if (jump)        cmd = CMD_JUMP;
        else if (call)   cmd = CMD_CALL;
        else if (ret)    cmd = CMD_RET;
        else if (branch) cmd = CMD_BRANCH;
        else if (incr_q) cmd = CMD_INCR;
    end

    always_comb begin
        pc_nxt  = pc;
        sp_nxt  = sp;
        push_en = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (cmd)
            CMD_JUMP: pc_nxt = target;
            CMD_CALL: begin
                if (!full) begin
                    push_en = 1'b1;
                    sp_nxt  = sp + ONE_SP;
                    pc_nxt  = target;
                end else begin
                    ovf_set = 1'b1;
                end
            end
            CMD_RET: begin
                if (!empty) begin
                    pc_nxt = stack[pop_idx];
                    sp_nxt = sp_dec;
                end else begin
                    unf_set = 1'b1;
                end
            end
            // Modulo-2^SIZE addition equals adding the sign-extended offset.
            CMD_BRANCH: pc_nxt = pc + offset;
            CMD_INCR:   pc_nxt = pc + STEP_V;
            default:    pc_nxt = pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc      <= RESET_V;
            sp      <= '0;
            incr_d  <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            pc      <= pc_nxt;
            sp      <= sp_nxt;
            incr_d  <= incr;
            // A new error in the same cycle as err_clr wins.
            err_ovf <= ovf_set | (err_ovf & ~err_clr);
            err_unf <= unf_set | (err_unf & ~err_clr);
        end
    end

    // Stack storage has no reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (reset_n && push_en) begin
            stack[push_idx] <= pc + STEP_V;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
module tb_pc_stack_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       incr, jump, branch, call, ret, err_clr;
    logic [7:0] target, offset;

    logic [7:0] pc,  pc_l;
    logic [2:0] sp,  sp_l;
    logic       full, empty, err_ovf, err_unf;
    logic       full_l, empty_l, err_ovf_l, err_unf_l;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pc_stack_unit #(.SIZE(8), .DEPTH(4), .STEP(1), .RESET_VEC(0), .EDGE_MODE(1)) dut (
        .clk(clk), .reset_n(reset_n), .incr(incr), .jump(jump), .branch(branch),
        .call(call), .ret(ret), .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc), .sp(sp), .full(full), .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    pc_stack_unit #(.SIZE(8), .DEPTH(4), .STEP(1), .RESET_VEC(0), .EDGE_MODE(0)) dut_lvl (
        .clk(clk), .reset_n(reset_n), .incr(incr), .jump(jump), .branch(branch),
        .call(call), .ret(ret), .target(target), .offset(offset), .err_clr(err_clr),
        .pc(pc_l), .sp(sp_l), .full(full_l), .empty(empty_l), .err_ovf(err_ovf_l),
        .err_unf(err_unf_l)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        incr = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic do_call(input logic [7:0] t);
        call = 1'b1; target = t;
        tick();
        call = 1'b0;
    endtask

    task automatic do_ret();
        ret = 1'b1;
        tick();
        ret = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        target = '0;
        offset = '0;
        #2;
        check("rst_pc",    32'(pc), 32'h00);
        check("rst_sp",    32'(sp), 32'h0);
        check("rst_empty", 32'(empty), 32'h1);
        check("rst_full",  32'(full), 32'h0);
        check("rst_ovf",   32'(err_ovf), 32'h0);
        check("rst_unf",   32'(err_unf), 32'h0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;

        // 1. edge vs level stepping
        incr = 1'b1;
        tick();
        check("edge_c1", 32'(pc), 32'h01);
        check("lvl_c1",  32'(pc_l), 32'h01);
        for (int i = 2; i <= 5; i++) tick();
        check("edge_hold", 32'(pc), 32'h01);
        check("lvl_c5",    32'(pc_l), 32'h05);
        incr = 1'b0;
        tick();
        check("edge_low", 32'(pc), 32'h01);
        check("lvl_low",  32'(pc_l), 32'h05);
        incr = 1'b1;
        tick();
        check("edge_2nd", 32'(pc), 32'h02);
        check("lvl_c6",   32'(pc_l), 32'h06);
        incr = 1'b0;
        tick();

        // 2. wrap and branch
        jump = 1'b1; target = 8'hFE;
        tick();
        jump = 1'b0;
        check("jump_fe", 32'(pc), 32'hFE);
        incr = 1'b1; tick(); incr = 1'b0;
        check("incr_ff", 32'(pc), 32'hFF);
        tick();
        incr = 1'b1; tick(); incr = 1'b0;
        check("incr_wrap", 32'(pc), 32'h00);
        branch = 1'b1; offset = 8'hFC;
        tick();
        check("br_neg", 32'(pc), 32'hFC);
        offset = 8'h05;
        tick();
        branch = 1'b0;
        check("br_pos_wrap", 32'(pc), 32'h01);

        // 3. call/return nesting
        jump = 1'b1; target = 8'h10; tick(); jump = 1'b0;
        do_call(8'h20);
        check("call1_pc", 32'(pc), 32'h20);
        check("call1_sp", 32'(sp), 32'h1);
        check("call1_empty", 32'(empty), 32'h0);
        do_call(8'h30);
        check("call2_sp", 32'(sp), 32'h2);
        do_call(8'h40);
        check("call3_sp", 32'(sp), 32'h3);
        check("call3_full", 32'(full), 32'h0);
        do_call(8'h50);
        check("call4_pc", 32'(pc), 32'h50);
        check("call4_sp", 32'(sp), 32'h4);
        check("call4_full", 32'(full), 32'h1);
        do_call(8'h60);
        check("ovf_pc",  32'(pc), 32'h50);
        check("ovf_sp",  32'(sp), 32'h4);
        check("ovf_flag", 32'(err_ovf), 32'h1);
        do_ret();
        check("ret1_pc", 32'(pc), 32'h41);
        check("ret1_sp", 32'(sp), 32'h3);
        check("ret1_full", 32'(full), 32'h0);
        do_ret();
        check("ret2_pc", 32'(pc), 32'h31);
        do_ret();
        check("ret3_pc", 32'(pc), 32'h21);
        do_ret();
        check("ret4_pc", 32'(pc), 32'h11);
        check("ret4_sp", 32'(sp), 32'h0);
        check("ret4_empty", 32'(empty), 32'h1);
        do_ret();
        check("unf_flag", 32'(err_unf), 32'h1);
        check("unf_pc",   32'(pc), 32'h11);
        check("unf_sp",   32'(sp), 32'h0);
        check("ovf_sticky", 32'(err_ovf), 32'h1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("clr_ovf", 32'(err_ovf), 32'h0);
        check("clr_unf", 32'(err_unf), 32'h0);
        check("clr_pc",  32'(pc), 32'h11);

        // 4. priority and consumed edge
        jump = 1'b1; call = 1'b1; branch = 1'b1; incr = 1'b1;
        target = 8'h80; offset = 8'h05;
        tick();
        jump = 1'b0; call = 1'b0; branch = 1'b0;
        check("prio_pc", 32'(pc), 32'h80);
        check("prio_sp", 32'(sp), 32'h0);
        tick();
        incr = 1'b0;
        check("edge_consumed", 32'(pc), 32'h80);

        // 5. error clear race
        do_call(8'h90);
        do_call(8'hA0);
        do_call(8'hB0);
        do_call(8'hC0);
        do_call(8'hD0);
        check("race_pre_ovf", 32'(err_ovf), 32'h1);
        check("race_pre_full", 32'(full), 32'h1);
        err_clr = 1'b1; call = 1'b1; target = 8'hE0;
        tick();
        call = 1'b0;
        check("race_set_wins", 32'(err_ovf), 32'h1);
        check("race_pc", 32'(pc), 32'hC0);
        tick();
        err_clr = 1'b0;
        check("clr_alone", 32'(err_ovf), 32'h0);
        check("clr_keeps_sp", 32'(sp), 32'h4);
        do_call(8'hE0);
        check("reovf", 32'(err_ovf), 32'h1);
        do_ret();
        check("ret_b1", 32'(pc), 32'hB1);
        do_ret();
        check("ret_a1", 32'(pc), 32'hA1);
        jump = 1'b1; target = 8'h33; tick(); jump = 1'b0;
        check("pre_rst_pc", 32'(pc), 32'h33);
        check("pre_rst_sp", 32'(sp), 32'h2);

        // 6. asynchronous reset between edges
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_pc",    32'(pc), 32'h00);
        check("arst_sp",    32'(sp), 32'h0);
        check("arst_empty", 32'(empty), 32'h1);
        check("arst_ovf",   32'(err_ovf), 32'h0);
        check("arst_unf",   32'(err_unf), 32'h0);
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        incr = 1'b1;
        tick();
        incr = 1'b0;
        check("post_rst_incr", 32'(pc), 32'h01);
        check("post_rst_sp",   32'(sp), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised program counter that supersedes the single-step PC. It adds level or edge-qualified stepping, a configurable step size, absolute jump, signed relative branch, and a hardware call/return stack with overflow and underflow detection. It sits between the instruction decoder, which issues one-cycle command strobes, and instruction memory, which consumes `pc` combinationally from the register.

Parameters:
SIZE, 8, PC width in bits; all PC arithmetic is modulo 2^SIZE.
DEPTH, 4, number of call-stack entries (≥1).
STEP, 1, increment amount applied on a qualified `incr`.
RESET_VEC, 0, PC value loaded at reset.
EDGE_MODE, 1, 1 = `incr` acts on its rising edge only; 0 = `incr` acts on every cycle it is high.

Ports:
clk  in  1  system clock; all state updates on its rising edge
reset_n  in  1  asynchronous active-low reset
incr  in  1  step request
jump  in  1  absolute load strobe
branch  in  1  relative branch strobe
call  in  1  push return address and jump
ret  in  1  pop return address into PC
target  in  SIZE  absolute address for `jump` and `call`
offset  in  SIZE  two's-complement signed offset for `branch`
err_clr  in  1  clears sticky error flags
pc  out  SIZE  current PC, taken directly from the register
sp  out  $clog2(DEPTH+1)  number of occupied stack entries
full  out  1  high when sp == DEPTH
empty  out  1  high when sp == 0
err_ovf  out  1  sticky flag: call issued while full
err_unf  out  1  sticky flag: ret issued while empty

Behaviour:
- Reset, asynchronous and effective immediately on `reset_n` low:
  - pc = RESET_VEC, sp = 0, empty = 1, full = 0, err_ovf = 0, err_unf = 0.
  - The edge-detect register `incr_d` = 0.
  - Stack contents are don't-care.
- Reset asserted mid-operation aborts any command in flight; no partial push or pop survives.
- `incr_d` <= `incr` on every clock edge, regardless of which command executes.
- Qualified increment:
  - EDGE_MODE=1: `incr & ~incr_d`.
  - EDGE_MODE=0: `incr`.
- Exactly one action per cycle, in fixed priority order:
  - jump > call > ret > branch > qualified incr.
  - Lower-priority requests in the same cycle are discarded, not queued.
  - An `incr` edge discarded this way is consumed, because `incr_d` still updates.
- jump: pc <= target.
- call:
  - If sp < DEPTH: stack[sp] <= pc + STEP (mod 2^SIZE), sp <= sp + 1, pc <= target.
  - If full: pc and sp unchanged, err_ovf <= 1.
- ret:
  - If sp > 0: pc <= stack[sp-1], sp <= sp - 1.
  - If empty: pc and sp unchanged, err_unf <= 1.
- branch: pc <= pc + sign-extended offset, with wrap (e.g. SIZE=8: pc 0x02, offset 0xFC -> 0xFE).
- Qualified incr: pc <= pc + STEP, with wrap (0xFF + 1 -> 0x00).
- No command: all state holds.
- Latency: every update is visible on `pc`, `sp`, `full` and `empty` one clock after the strobe. No output has a combinational path from any input.
- `full` and `empty` are decoded from registered `sp`.
- Error flags:
  - They stay set until `err_clr` is high at a clock edge.
  - If `err_clr` and a new error condition occur in the same cycle, the set wins and the flag stays 1.
  - `err_clr` does not affect pc, sp or the stack.
- Stack is LIFO:
  - A call while sp == DEPTH-1 fills the last entry and raises `full`.
  - A ret that takes sp from 1 to 0 raises `empty`.

Test Plan:
1. Edge stepping: after reset (RESET_VEC=0, EDGE_MODE=1), hold `incr` high for 5 cycles, low for 1, high for 1 -> pc goes 0 -> 1, holds at 1, then -> 2. Repeat with EDGE_MODE=0 -> pc increments on each high cycle, reaching 6.
2. Wrap and branch: jump to 0xFE, then incr edge -> 0xFF, incr edge -> 0x00. Branch with offset 0xFC from 0x00 -> 0xFC. Branch with offset 0x05 -> 0x01.
3. Call/return nesting (DEPTH=4):
   - From pc 0x10, four calls to 0x20, 0x30, 0x40, 0x50 -> sp 1..4, full=1 after the fourth.
   - A fifth call to 0x60 -> pc stays 0x50, err_ovf=1.
   - Four rets -> pc 0x41, 0x31, 0x21, 0x11, sp back to 0, empty=1.
   - A further ret -> err_unf=1, pc stays 0x11.
4. Priority: in one cycle assert jump (target 0x80), call, branch and an incr edge -> pc = 0x80, sp unchanged. Keep `incr` high the next cycle -> no increment, because the edge was consumed.
5. Error clear race: with err_ovf=1 and full=1, assert `err_clr` and `call` together -> err_ovf stays 1. Assert `err_clr` alone -> err_ovf = 0.
6. Asynchronous reset mid-operation: assert `reset_n` low between clock edges while sp=2 and pc=0x33 -> pc = RESET_VEC, sp = 0, empty = 1 and both error flags = 0 immediately, before the next edge. After release, the first incr edge -> pc = RESET_VEC + STEP.
